// File: rtl/k_means_pkg.sv
// Shared types and default sizes for the k-means sequencer.
package k_means_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 91;
    localparam int DEF_K          = 4;
    localparam int DEF_ITER_WIDTH = 8;

    // Register number that receives the iteration count after the K centroids.
    localparam int ITER_REG_NUM   = DEF_K;

    typedef logic [DEF_DATA_WIDTH-1:0] point_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_STREAM,
        S_UPDATE,
        S_CHECK,
        S_WRITEBACK,
        S_DONE
    } state_t;

endpackage

// File: rtl/k_means_point_streamer.sv
// Reads addresses 0..len-1 from a 1-cycle-latency RAM and presents them in
// order through a one-entry valid/accept holding register. A returning word is
// offered directly in its arrival cycle and parked in the holding register only
// if it is not taken, so full throughput is one word per cycle. The address
// counter clears when disabled or on the final accept, ready for the next pass.
module k_means_point_streamer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 91
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  accept,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic                  took;
    logic                  issue;

    // A word is in flight from RAM (pending) or parked (hold_valid), never both.
    assign out_valid = pending | hold_valid;
    assign out_data  = hold_valid ? hold_data : (pending ? ram_rd_data : '0);
    assign out_addr  = hold_valid ? hold_addr : pend_addr;
    assign took      = out_valid && accept;
    assign last      = took && (out_addr == len - 1'b1);

    // Only read when the output slot is empty or is being emptied this cycle.
    assign issue     = enable && (rd_addr < len) && (!out_valid || accept);
    assign ram_rd_en = issue;
    assign ram_addr  = issue ? rd_addr : '0;

    // Address counter, in-flight flag and holding-register occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr    <= '0;
            pending    <= 1'b0;
            pend_addr  <= '0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
        end else if (!enable || last) begin
            rd_addr    <= '0;
            pending    <= 1'b0;
            pend_addr  <= '0;
            hold_valid <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                rd_addr   <= rd_addr + 1'b1;
                pend_addr <= rd_addr;
            end
            if (pending && !accept) begin
                hold_valid <= 1'b1;
                hold_addr  <= pend_addr;
            end else if (hold_valid && accept) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Holding-register payload.
    // NOTE: the wide data register has no reset; it is only observed while
    // hold_valid is set, which is reset, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (enable && pending && !accept) begin
            hold_data <= ram_rd_data;
        end
    end

endmodule

// File: rtl/k_means_ctrl.sv
// Sequencer for the k-means datapath: seeds K centroids from point RAM,
// streams all points once per iteration, requests a centroid update, repeats
// up to cfg_max_iter times, then writes centroids and the iteration count to
// the register file and pulses irq.
// Build option: K_MEANS_CONV_CHECK_EN lets the CHECK state also finish early
// when the datapath reports convergence.
module k_means_ctrl
    import k_means_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = DEF_K,
    parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] cfg_num_points,
    input  logic [ITER_WIDTH-1:0] cfg_max_iter,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  dp_cent_load,
    output logic [$clog2(K)-1:0]  dp_cent_idx,
    input  logic [DATA_WIDTH-1:0] dp_cent_rd_data,
    output logic                  dp_point_valid,
    output logic [DATA_WIDTH-1:0] dp_point,
    input  logic                  dp_ready,
    output logic                  dp_update_req,
    input  logic                  dp_update_done,
    input  logic                  dp_converged,
    output logic [ADDR_WIDTH-1:0] reg_num,
    output logic                  reg_w_r,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    output logic                  irq,
    output logic                  busy
);

    localparam int                    IDX_WIDTH = $clog2(K);
    localparam logic [ADDR_WIDTH-1:0] K_ADDR    = ADDR_WIDTH'(K);
    localparam logic [ITER_WIDTH-1:0] ITER_SAT  = '1;

    state_t                state;
    state_t                state_next;
    logic                  go_q;
    logic                  go_rise;
    logic [ADDR_WIDTH-1:0] num_points;
    logic [ITER_WIDTH-1:0] max_iter;
    logic [ITER_WIDTH-1:0] iter;
    logic [ADDR_WIDTH-1:0] wb_cnt;
    logic                  upd_sent;
    logic                  done_cond;

    logic                  stream_en;
    logic                  stream_accept;
    logic [ADDR_WIDTH-1:0] stream_len;
    logic                  stream_valid;
    logic [DATA_WIDTH-1:0] stream_data;
    logic [ADDR_WIDTH-1:0] stream_addr;
    logic                  stream_last;

    assign go_rise    = go && !go_q;
    assign busy       = (state != S_IDLE);
    assign stream_en  = (state == S_SEED) || (state == S_STREAM);
    assign stream_len = (state == S_SEED) ? K_ADDR : num_points;
    assign dp_point   = stream_data;

`ifdef K_MEANS_CONV_CHECK_EN
    assign done_cond = (iter == max_iter) || dp_converged;
`else
    assign done_cond = (iter == max_iter);
    logic unused_converged;
    assign unused_converged = dp_converged;
`endif

    k_means_point_streamer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_streamer (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (stream_en),
        .len         (stream_len),
        .accept      (stream_accept),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .out_valid   (stream_valid),
        .out_data    (stream_data),
        .out_addr    (stream_addr),
        .last        (stream_last)
    );

    // State register, latched configuration, iteration and writeback counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            go_q       <= 1'b0;
            num_points <= '0;
            max_iter   <= '0;
            iter       <= '0;
            wb_cnt     <= '0;
            upd_sent   <= 1'b0;
        end else begin
            state    <= state_next;
            go_q     <= go;
            upd_sent <= (state == S_UPDATE);
            case (state)
                S_IDLE: begin
                    if (go_rise) begin
                        num_points <= cfg_num_points;
                        max_iter   <= cfg_max_iter;
                        iter       <= '0;
                        // Count-only runs skip straight to the iteration register.
                        wb_cnt     <= (cfg_num_points < K_ADDR) ? K_ADDR : '0;
                    end
                end
                S_UPDATE: begin
                    if (dp_update_done && (iter != ITER_SAT)) begin
                        iter <= iter + 1'b1;
                    end
                end
                S_WRITEBACK: wb_cnt <= wb_cnt + 1'b1;
                S_DONE:      wb_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    // NOTE: every output and next-state gets a default before the case, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        stream_accept  = 1'b0;
        dp_cent_load   = 1'b0;
        dp_cent_idx    = '0;
        dp_point_valid = 1'b0;
        dp_update_req  = 1'b0;
        reg_num        = '0;
        reg_w_r        = 1'b0;
        reg_write_data = '0;
        irq            = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_rise) begin
                    state_next = (cfg_num_points < K_ADDR) ? S_WRITEBACK : S_SEED;
                end
            end
            S_SEED: begin
                // Seeds are loaded as they arrive; the datapath cannot stall them.
                stream_accept = stream_valid;
                dp_cent_load  = stream_valid;
                dp_cent_idx   = IDX_WIDTH'(stream_addr);
                if (stream_last) begin
                    state_next = (max_iter == '0) ? S_WRITEBACK : S_STREAM;
                end
            end
            S_STREAM: begin
                stream_accept  = dp_ready;
                dp_point_valid = stream_valid;
                if (stream_last) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                dp_update_req = !upd_sent;
                if (dp_update_done) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = done_cond ? S_WRITEBACK : S_STREAM;
            end
            S_WRITEBACK: begin
                reg_w_r = 1'b1;
                reg_num = wb_cnt;
                if (wb_cnt < K_ADDR) begin
                    dp_cent_idx    = IDX_WIDTH'(wb_cnt);
                    reg_write_data = dp_cent_rd_data;
                end else begin
                    reg_write_data = DATA_WIDTH'(iter);
                    state_next     = S_DONE;
                end
            end
            S_DONE: begin
                irq        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
